// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU adder.
//   SLICE_W          width of the shared carry-look-ahead slice
//   alu_seq_state_t  controller states (IDLE, RUN, DONE)
package alu_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_seq_state_t;

endpackage

// File: rtl/add_slice_4bit.sv
// add_slice_4bit: combinational 4-bit carry-look-ahead adder slice.
// Ports:
//   a, b   [3:0]  slice operands
//   c_in          carry into bit 0
//   sum    [3:0]  slice sum
//   c_out         carry out of bit 3
module add_slice_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Every carry is computed directly from generate/propagate terms,
    // so no carry ripples through a previous bit's carry.
    assign c_s[0] = c_in;
    assign c_s[1] = g_s[0] | (p_s[0] & c_in);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_in);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_in);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_in);

    assign sum   = p_s ^ c_s[3:0];
    assign c_out = c_s[4];

endmodule

// File: rtl/alu_seq_adder.sv
// alu_seq_adder: multi-cycle WIDTH-bit adder/subtractor that reuses one
// 4-bit carry-look-ahead slice, least-significant nibble first.
// Build option: define ALU_SEQ_SUB_EN to honour op_sub (A - B); when it is
// undefined op_sub is ignored and every operation is A + B + c_in.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   a, b, c_in, op_sub    operands, sampled on the request handshake
//   out_valid / out_ready result handshake
//   result, c_out         registered sum/difference and final carry
//                         (subtract: c_out = 1 means no borrow)
//   busy                  high while in RUN or DONE
module alu_seq_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    alu_seq_state_t   state_r;
    alu_seq_state_t   state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] result_r;
    logic             c_out_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [WIDTH-1:0]   b_eff_s;
    logic               c_init_s;
    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_co_s;
    logic               last_s;

`ifdef ALU_SEQ_SUB_EN
    // Subtraction as A + ~B + 1; the user carry-in is irrelevant then.
    assign b_eff_s  = op_sub ? ~b : b;
    assign c_init_s = op_sub ? 1'b1 : c_in;
`else
    logic unused_op_sub_s;
    assign unused_op_sub_s = op_sub;
    assign b_eff_s         = b;
    assign c_init_s        = c_in;
`endif

    assign slice_a_s = a_r[idx_r*SLICE_W +: SLICE_W];
    assign slice_b_s = b_r[idx_r*SLICE_W +: SLICE_W];
    assign last_s    = (idx_r == IDX_W'(NSLICE - 1));

    add_slice_4bit u_slice (
        .a     (slice_a_s),
        .b     (slice_b_s),
        .c_in  (carry_r),
        .sum   (slice_sum_s),
        .c_out (slice_co_s)
    );

    // Next-state logic of the IDLE/RUN/DONE controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state
    // so they change in the same cycle as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    // Operand capture and one-nibble-per-cycle accumulation of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx_r    <= '0;
            result_r <= '0;
            c_out_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b_eff_s;
                        carry_r <= c_init_s;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    result_r[idx_r*SLICE_W +: SLICE_W] <= slice_sum_s;
                    carry_r <= slice_co_s;
                    if (last_s) begin
                        c_out_r <= slice_co_s;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign c_out     = c_out_r;

endmodule

// File: tb/tb_alu_seq_adder.sv
// tb_alu_seq_adder: directed self-checking bench for alu_seq_adder (WIDTH=16).
module tb_alu_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        c_out;
    logic        busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    alu_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and wait (bounded) for out_valid; lat counts
    // cycles from the handshake cycle (cycle 0) to the first out_valid cycle.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vs, output int lat);
        check_val("ready_before_issue", {31'd0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        c_in     = vc;
        op_sub   = vs;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vs,
                         input logic [15:0] exp_res, input logic exp_co);
        int lat;
        issue(va, vb, vc, vs, lat);
        check_val({tag, "_latency"}, lat, 32'd5);
        check_val({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
        check_val({tag, "_c_out"}, {31'd0, c_out}, {31'd0, exp_co});
        finish_op(tag);
    endtask

    initial begin
        int   lat;
        int   e;
        int   acc1;
        int   acc2;
        int   ouths;
        int   lat2;
        logic hs_in;
        logic hs_out;
        logic saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        c_in      = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_result", {16'd0, result}, 32'd0);
        check_val("rst_c_out", {31'd0, c_out}, 32'd0);
        rst_n = 1'b1;
        step();

        // Carry ripples through every nibble.
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        // Carry-in honoured, carry out of the top nibble.
        do_op("add_cin", 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1);
`ifdef ALU_SEQ_SUB_EN
        // c_in=0 must be ignored in subtract mode.
        do_op("sub_pos", 16'h1234, 16'h0235, 1'b0, 1'b1, 16'h0FFF, 1'b1);
        do_op("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0);
`else
        do_op("sub_off", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h0012, 1'b0);
`endif

        // Backpressure: ten cycles of out_ready low in DONE.
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
        check_val("bp_latency", lat, 32'd5);
        for (int i = 0; i < 10; i++) begin
            check_val("bp_result", {16'd0, result}, 32'h0000_1000);
            check_val("bp_c_out", {31'd0, c_out}, 32'd0);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("bp_busy", {31'd0, busy}, 32'd1);
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        finish_op("bp");

        // Reset in the second RUN cycle discards the operation.
        a        = 16'h1111;
        b        = 16'h2222;
        c_in     = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_result", {16'd0, result}, 32'd0);
        check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check_val("mid_rst_no_output", {31'd0, saw_valid}, 32'd0);
        do_op("after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        e         = 0;
        acc1      = -1;
        acc2      = -1;
        ouths     = -1;
        a         = 16'h0102;
        b         = 16'h0304;
        c_in      = 1'b0;
        op_sub    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && acc2 < 0; k++) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out && ouths < 0) begin
                check_val("b2b_first_result", {16'd0, result}, 32'h0000_0406);
            end
            step();
            e++;
            if (hs_in) begin
                if (acc1 < 0) begin
                    acc1 = e;
                    a    = 16'hABCD;
                    b    = 16'h1111;
                end else begin
                    acc2 = e;
                end
            end
            if (hs_out && ouths < 0) ouths = e;
        end
        in_valid = 1'b0;
        check_val("b2b_interval", acc2 - acc1, 32'd6);
        check_val("b2b_after_out_hs", acc2 - ouths, 32'd1);
        lat2 = 0;
        while (!out_valid && lat2 < 20) begin
            step();
            lat2++;
        end
        check_val("b2b_second_latency", lat2, 32'd4);
        check_val("b2b_second_result", {16'd0, result}, 32'h0000_BCDE);
        check_val("b2b_second_c_out", {31'd0, c_out}, 32'd0);
        step();
        out_ready = 1'b0;
        check_val("b2b_end_ready", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
